seq_scan_ctrl: RTL and testbench
================================

SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

Interface
REQ-001 clk  input  1  single clock; all state updates on posedge clk.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 clr  input  1  synchronous abort/clear, active-high.
REQ-004 in_word  input  16  word to scan, consumed MSB (bit 15) first.
REQ-005 in_valid  input  1  in_word valid.
REQ-006 in_ready  output  1  block can accept a word (high only in IDLE).
REQ-007 busy  output  1  scan in progress (high only in SCAN).
REQ-008 done  output  1  one-cycle pulse; results valid.
REQ-009 match_count  output  5  number of 10110 detections in the last word.
REQ-010 match_pos  output  16  bit i set if a detection completed on in_word bit i.
REQ-011 det_state  output  3  current detector state encoding S0..S4 = 0..4.

Function
REQ-012 The controller FSM SHALL have three states, IDLE, SCAN and DONE, with no other reachable state; an illegal encoding SHALL go to IDLE.
REQ-013 IDLE: a word is accepted when in_valid=1 at a clock edge, because in_ready=1 in IDLE. On acceptance the block latches in_word, sets bit index 15, clears match_count and match_pos, and goes to SCAN.
REQ-014 SCAN: each edge consumes the indexed bit and then decrements the index. After the edge that consumes bit 0 (the 16th scan edge), the FSM goes to DONE.
REQ-015 DONE: done=1 for exactly one cycle; the next edge goes to IDLE.
REQ-016 Latency: acceptance at edge N; bits consumed at edges N+1..N+16; done is high between edges N+16 and N+17.
REQ-017 in_valid outside IDLE SHALL be ignored and SHALL NOT alter any state.
REQ-018 The detector SHALL be an overlapping Mealy detector for 10110 with these transitions (bit=0 / bit=1):
- S0: S0 / S1
- S1: S2 / S1
- S2: S0 / S3
- S3: S2 / S4
- S4: S2 with match / S1
REQ-019 On a match while consuming bit i, match_pos[i] SHALL be set and match_count SHALL increment, both on the same edge.
REQ-020 match_count and match_pos SHALL hold their values from DONE through IDLE until the next acceptance or clr.
REQ-021 clr=1 at an edge SHALL force IDLE, S0, match_count=0 and match_pos=0. clr SHALL take priority over in_valid, and a word presented in the same cycle SHALL NOT be accepted.
REQ-022 The detector SHALL advance only on SCAN edges and SHALL hold its state otherwise.

Reset
REQ-023 While reset=1: IDLE, det_state=S0, in_ready=1, busy=0, done=0, match_count=0, match_pos=0, and the latched word and index are zero, asynchronously, including mid-scan.
REQ-024 After reset deasserts, the first acceptance is possible at the first clock edge.

Configuration
REQ-025 Macro SEQ_SCAN_CARRY_EN:
- Defined: detector state SHALL carry over from the end of one word into the next word, so a pattern may straddle two words.
- Undefined: the detector SHALL reset to S0 on every acceptance.
- clr and reset SHALL force S0 in both builds.

Verification
REQ-026 Accept 0x5B36 -> done at edge N+16, match_count=3, match_pos=0x0481, det_state=S2.
REQ-027 Accept 0xB6DB -> match_count=4, match_pos=0x0924, det_state=S4.
REQ-028 Accept 0x000B, then 0x0000:
- With SEQ_SCAN_CARRY_EN: second result match_count=1, match_pos=0x8000.
- Without it: second result match_count=0, match_pos=0x0000.
REQ-029 Accept 0xFFFF, then hold in_valid=1 with 0xB6DB during SCAN -> first result count=0, pos=0x0000, in_ready=0; 0xB6DB is accepted only after returning to IDLE.
REQ-030 Accept 0x5B36, assert clr at scan edge 5 -> IDLE with outputs cleared and no done pulse; a repeat with reset mid-scan gives the same outputs immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: scans 16-bit words MSB first for overlapping 10110; define SEQ_SCAN_CARRY_EN to carry detector state across words
module seq_scan_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        clr,
   input  logic [15:0] in_word,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        busy,
   output logic        done,
   output logic [4:0]  match_count,
   output logic [15:0] match_pos,
   output logic [2:0]  det_state
);
   typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;
   typedef enum logic [2:0] {S0 = 3'd0, S1 = 3'd1, S2 = 3'd2, S3 = 3'd3, S4 = 3'd4} det_t;
   state_t      state_q, state_d;
   det_t        det_q, det_d, step_c;
   logic [15:0] word_q, word_d, pos_q, pos_d;
   logic [3:0]  idx_q, idx_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        bit_c, hit_c;
   // one detector step on the currently indexed bit; a match completes on the 0 after 1011
   always_comb begin
      bit_c  = word_q[idx_q];
      hit_c  = 1'b0;
      step_c = S0;
      case (det_q)
         S0:      step_c = bit_c ? S1 : S0;
         S1:      step_c = bit_c ? S1 : S2;
         S2:      step_c = bit_c ? S3 : S0;
         S3:      step_c = bit_c ? S4 : S2;
         S4: begin
            step_c = bit_c ? S1 : S2;
            hit_c  = ~bit_c;
         end
         default: step_c = S0;
      endcase
   end
   // controller next state; clr overrides everything, including a word offered in IDLE
   always_comb begin
      state_d = state_q;
      det_d   = det_q;
      word_d  = word_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      pos_d   = pos_q;
      case (state_q)
         IDLE: if (in_valid) begin
            state_d = SCAN;
            word_d  = in_word;
            idx_d   = 4'd15;
            cnt_d   = '0;
            pos_d   = '0;
`ifdef SEQ_SCAN_CARRY_EN
            det_d   = det_q;
`else
            det_d   = S0;
`endif
         end
         SCAN: begin
            det_d = step_c;
            idx_d = idx_q - 4'd1;
            if (hit_c) begin
               cnt_d        = cnt_q + 5'd1;
               pos_d[idx_q] = 1'b1;
            end
            if (idx_q == 4'd0) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (clr) begin
         state_d = IDLE;
         det_d   = S0;
         cnt_d   = '0;
         pos_d   = '0;
      end
   end
   // state registers with asynchronous reset to an idle, cleared block
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         det_q   <= S0;
         word_q  <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         pos_q   <= '0;
      end else begin
         state_q <= state_d;
         det_q   <= det_d;
         word_q  <= word_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         pos_q   <= pos_d;
      end
   end
   assign in_ready    = state_q == IDLE;
   assign busy        = state_q == SCAN;
   assign done        = state_q == DONE;
   assign match_count = cnt_q;
   assign match_pos   = pos_q;
   assign det_state   = det_q;
endmodule

// File: tb/tb_seq_scan_ctrl.sv
// tb_seq_scan_ctrl: directed vectors with hand-computed results for seq_scan_ctrl
module tb_seq_scan_ctrl;
   logic        clk, reset, clr, in_valid;
   logic [15:0] in_word;
   logic        in_ready, busy, done;
   logic [4:0]  match_count;
   logic [15:0] match_pos;
   logic [2:0]  det_state;
   int          n_chk = 0;
   int          n_bad = 0;
   int          lat;

   seq_scan_ctrl dut (
      .clk(clk), .reset(reset), .clr(clr), .in_word(in_word), .in_valid(in_valid),
      .in_ready(in_ready), .busy(busy), .done(done), .match_count(match_count),
      .match_pos(match_pos), .det_state(det_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic accept(input logic [15:0] w);
      in_word  = w;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < 40) begin
         tick();
         n++;
      end
   endtask

   task automatic check_result(input string tag, input logic [4:0] c, input logic [15:0] p, input logic [2:0] d);
      chk({tag, " latency"}, 32'(lat), 32'd16);
      chk({tag, " done"}, 32'(done), 32'd1);
      chk({tag, " count"}, 32'(match_count), 32'(c));
      chk({tag, " pos"}, 32'(match_pos), 32'(p));
      chk({tag, " det"}, 32'(det_state), 32'(d));
   endtask

   task automatic check_idle(input string tag);
      chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
      chk({tag, " busy"}, 32'(busy), 32'd0);
      chk({tag, " done"}, 32'(done), 32'd0);
      chk({tag, " count"}, 32'(match_count), 32'd0);
      chk({tag, " pos"}, 32'(match_pos), 32'd0);
      chk({tag, " det"}, 32'(det_state), 32'd0);
   endtask

   initial begin
      reset = 1'b0; clr = 1'b0; in_valid = 1'b0; in_word = 16'h0;
      #1 reset = 1'b1;
      #1 check_idle("reset");
      tick();
      @(negedge clk) reset = 1'b0;

      // 0x5B36: matches on bits 10, 7, 0
      accept(16'h5B36);
      chk("w1 busy", 32'(busy), 32'd1);
      chk("w1 in_ready", 32'(in_ready), 32'd0);
      wait_done(lat);
      check_result("w1", 5'd3, 16'h0481, 3'd2);
      tick();
      chk("w1 back idle", 32'(in_ready), 32'd1);
      chk("w1 done pulse", 32'(done), 32'd0);
      chk("w1 count held", 32'(match_count), 32'd3);
      chk("w1 pos held", 32'(match_pos), 32'h0481);
      tick();
      chk("w1 det held", 32'(det_state), 32'd2);

      // 0xB6DB: matches on bits 11, 8, 5, 2
      accept(16'hB6DB);
      wait_done(lat);
      check_result("w2", 5'd4, 16'h0924, 3'd4);
      tick();

      // clr together with a valid word in IDLE: not accepted
      clr = 1'b1; in_valid = 1'b1; in_word = 16'h5B36;
      tick();
      clr = 1'b0; in_valid = 1'b0;
      check_idle("clr vs valid");

      // 0x000B ends in S4; 0x0000 then matches on bit 15 only when state carries
      accept(16'h000B);
      wait_done(lat);
      check_result("w3a", 5'd0, 16'h0000, 3'd4);
      tick();
      accept(16'h0000);
      wait_done(lat);
`ifdef SEQ_SCAN_CARRY_EN
      check_result("w3b", 5'd1, 16'h8000, 3'd0);
`else
      check_result("w3b", 5'd0, 16'h0000, 3'd0);
`endif
      tick();

      // 0xFFFF with in_valid held high during the scan
      in_word = 16'hFFFF; in_valid = 1'b1;
      tick();
      in_word = 16'hB6DB;
      tick();
      chk("w4 in_ready scan", 32'(in_ready), 32'd0);
      chk("w4 busy scan", 32'(busy), 32'd1);
      lat = 1;
      while (!done && lat < 40) begin
         tick();
         lat++;
      end
      check_result("w4", 5'd0, 16'h0000, 3'd1);
      tick();
      chk("w4 idle again", 32'(in_ready), 32'd1);
      chk("w4 count held", 32'(match_count), 32'd0);
      tick();
      in_valid = 1'b0;
      chk("w4 late accept", 32'(busy), 32'd1);
      wait_done(lat);
      check_result("w5", 5'd4, 16'h0924, 3'd4);
      tick();

      // clr at scan edge 5 of 0x5B36
      accept(16'h5B36);
      repeat (4) tick();
      chk("clr pre det", 32'(det_state), 32'd3);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check_idle("clr mid");
      lat = 0;
      repeat (20) begin
         tick();
         if (done) lat++;
      end
      chk("clr no done", 32'(lat), 32'd0);

      // reset asserted mid-scan of 0xB6DB after 10 scan edges
      accept(16'hB6DB);
      repeat (10) tick();
      chk("rst pre count", 32'(match_count), 32'd2);
      chk("rst pre pos", 32'(match_pos), 32'h0900);
      chk("rst pre det", 32'(det_state), 32'd4);
      #2 reset = 1'b1;
      #1 check_idle("rst mid");
      @(negedge clk) reset = 1'b0;
      accept(16'h5B36);
      chk("rst first accept", 32'(busy), 32'd1);
      wait_done(lat);
      check_result("w6", 5'd3, 16'h0481, 3'd2);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
